xy_motion_sequencer: RTL and testbench
======================================

Name: xy_motion_sequencer

Overview:
Sequences one plotter move per command: sets the pen servo, waits for it to settle, then issues coordinated X/Y step pulses with a DDA line interpolator so both axes finish together. It replaces direct register-driven stepping, sitting between the processor's command registers and the x/y stepper drivers and servo_controller. Commands are accepted with a valid/ready handshake, and completion is flagged by a one-cycle done pulse.

Parameters:
CW, 16, width of per-axis step magnitude
STEP_DIV, 50000, clocks per step period (50 MHz -> 1 kHz)
PULSE_W, 500, step pulse high time in clocks; must satisfy 1 <= PULSE_W < STEP_DIV
PEN_SETTLE, 12500000, clocks to wait after a pen change (0.25 s)

Ports:
clk  in  1  master clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_dx  in  CW  X step count (unsigned magnitude)
cmd_dy  in  CW  Y step count (unsigned magnitude)
cmd_x_dir  in  1  X direction for this move
cmd_y_dir  in  1  Y direction for this move
cmd_pen  in  1  requested pen state, 1 = down
x_step  out  1  X step pulse to the stepper driver
y_step  out  1  Y step pulse to the stepper driver
x_dir  out  1  latched X direction
y_dir  out  1  latched Y direction
pen_down  out  1  pen state to the servo select (1 = down position)
busy  out  1  high when the state is not IDLE
done  out  1  one-cycle pulse at move completion

Behaviour:
- Reset (async, any state, including mid-move): state=IDLE and all counters/accumulators cleared. Outputs: x_step=y_step=0, x_dir=y_dir=0, pen_down=0 (pen up), busy=0, done=0. cmd_ready=0 while reset is asserted and 1 from the first clock after release.
- States: IDLE, PEN, STEP, DONE.
- cmd_ready = (state==IDLE) and not reset. A command is accepted at cycle T when cmd_valid and cmd_ready are both high.
- On accept:
  - Latch dx, dy, x_dir, y_dir, and N = max(dx, dy).
  - Initialise both accumulators to floor(N/2).
  - x_dir/y_dir outputs update at T+1 and hold stable until the next accept.
- Transition from IDLE at T+1:
  - cmd_pen != pen_down: pen_down <= cmd_pen, go to PEN.
  - Else if N > 0: go to STEP.
  - Else: go to DONE.
- PEN: count PEN_SETTLE clocks. Then go to STEP if N > 0, else to DONE.
- STEP: runs N step periods of STEP_DIV clocks each.
  - At the first clock of each period, add dx to the X accumulator. If the result >= N, subtract N and set the X pulse flag for this period; otherwise clear it.
  - Apply the same rule to Y with dy.
  - Accumulators are CW+1 bits wide. No overflow is possible because acc < N before the add.
  - x_step/y_step are high for the first PULSE_W clocks of a period whose flag is set, and low otherwise.
  - The major axis pulses every period. The minor axis pulses exactly min(dx, dy) times. dx == dy gives simultaneous pulses.
  - After the last clock of period N, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy: 1 in PEN, STEP, and DONE.
- Commands presented while busy are ignored (not latched). cmd_valid held through DONE is accepted in the first IDLE cycle.
- Step outputs are registered and glitch-free. They are never high outside STEP.

Test Plan:
All scenarios use STEP_DIV=10, PULSE_W=2, PEN_SETTLE=20, with pen initially up.
- Straight X move: cmd dx=4, dy=0, pen=0, accepted at T -> four x_step pulses, each 2 clocks wide, rising at T+1, T+11, T+21, T+31. y_step stays 0. done pulses at T+41. busy is high T+1..T+41.
- Diagonal ratio: dx=4, dy=2 -> x_step pulses in all 4 periods. y_step pulses only in periods 1 and 3 (accumulator sequence 2->4(pulse)->0->2->4(pulse)->0). Total y pulses = 2.
- Pen change: dx=0, dy=3, pen=1, y_dir=1 at T -> pen_down=1 and y_dir=1 at T+1. No step pulse before T+21. Three y_step pulses at T+21, T+31, T+41. done at T+51.
- Zero move, same pen: dx=dy=0, pen=0 -> done at T+1. No step pulses. cmd_ready back to 1 at T+2.
- Busy and reset: with a dx=5 move in progress, a new cmd_valid during STEP is not accepted. Asserting reset in period 3 -> x_step=0 and pen_down=0 immediately (asynchronously). After release, the next command starts fresh with a floor(N/2) accumulator and no residual pulses.
- Back-to-back: cmd_valid held high with two queued commands -> the second is accepted in the cycle after done, and its dir outputs change only then.

Source files
------------

// File: rtl/xy_motion_sequencer.sv
// Plotter move sequencer: optional pen change with settle delay, then DDA-interpolated
// X/Y step pulses so both axes finish on the same step period.
module xy_motion_sequencer #(
    parameter int CW         = 16,
    parameter int STEP_DIV   = 50000,
    parameter int PULSE_W    = 500,
    parameter int PEN_SETTLE = 12500000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [CW-1:0] cmd_dx,
    input  logic [CW-1:0] cmd_dy,
    input  logic          cmd_x_dir,
    input  logic          cmd_y_dir,
    input  logic          cmd_pen,
    output logic          x_step,
    output logic          y_step,
    output logic          x_dir,
    output logic          y_dir,
    output logic          pen_down,
    output logic          busy,
    output logic          done
);
    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int SW = (PEN_SETTLE > 1) ? $clog2(PEN_SETTLE) : 1;
    localparam logic [PW-1:0] PHASE_LAST  = PW'(STEP_DIV - 1);
    localparam logic [PW-1:0] PULSE_LAST  = PW'(PULSE_W - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'((PEN_SETTLE > 0) ? PEN_SETTLE - 1 : 0);

    typedef enum logic [1:0] {IDLE, PEN, STEP, DONE} state_t;
    state_t state, state_next;

    logic [CW-1:0] dx_r, dy_r, n_r, periods_left;
    logic [CW:0]   acc_x, acc_y;
    logic [PW-1:0] phase;
    logic [SW-1:0] settle;

    logic [CW-1:0] cmd_n, n_sel, d_x, d_y;
    logic [CW:0]   base_x, base_y, sum_x, sum_y, acc_x_next, acc_y_next;
    logic          hit_x, hit_y, accept, pen_change, period_start;

    assign cmd_ready  = (state == IDLE) && !reset;
    assign accept     = cmd_valid && cmd_ready;
    assign pen_change = cmd_pen != pen_down;
    assign cmd_n      = (cmd_dx > cmd_dy) ? cmd_dx : cmd_dy;
    assign busy       = state != IDLE;
    assign done       = state == DONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        period_start = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (pen_change) begin
                    state_next = PEN;
                end else if (cmd_n != '0) begin
                    state_next   = STEP;
                    period_start = 1'b1;
                end else begin
                    state_next = DONE;
                end
            end
            PEN: if (settle == SETTLE_LAST) begin
                if (n_r != '0) begin
                    state_next   = STEP;
                    period_start = 1'b1;
                end else begin
                    state_next = DONE;
                end
            end
            STEP: if (phase == PHASE_LAST) begin
                if (periods_left == '0) state_next = DONE;
                else                    period_start = 1'b1;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A move going straight from IDLE to STEP takes its first DDA add from the command inputs.
    always_comb begin
        if (state == IDLE) begin
            n_sel  = cmd_n;
            d_x    = cmd_dx;
            d_y    = cmd_dy;
            base_x = {1'b0, cmd_n >> 1};
            base_y = {1'b0, cmd_n >> 1};
        end else begin
            n_sel  = n_r;
            d_x    = dx_r;
            d_y    = dy_r;
            base_x = acc_x;
            base_y = acc_y;
        end
        sum_x      = base_x + {1'b0, d_x};
        sum_y      = base_y + {1'b0, d_y};
        hit_x      = sum_x >= {1'b0, n_sel};
        hit_y      = sum_y >= {1'b0, n_sel};
        acc_x_next = hit_x ? sum_x - {1'b0, n_sel} : sum_x;
        acc_y_next = hit_y ? sum_y - {1'b0, n_sel} : sum_y;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dx_r         <= '0;
            dy_r         <= '0;
            n_r          <= '0;
            periods_left <= '0;
            acc_x        <= '0;
            acc_y        <= '0;
            phase        <= '0;
            settle       <= '0;
            x_step       <= 1'b0;
            y_step       <= 1'b0;
            x_dir        <= 1'b0;
            y_dir        <= 1'b0;
            pen_down     <= 1'b0;
        end else begin
            if (accept) begin
                dx_r   <= cmd_dx;
                dy_r   <= cmd_dy;
                n_r    <= cmd_n;
                x_dir  <= cmd_x_dir;
                y_dir  <= cmd_y_dir;
                acc_x  <= {1'b0, cmd_n >> 1};
                acc_y  <= {1'b0, cmd_n >> 1};
                settle <= '0;
                if (pen_change) pen_down <= cmd_pen;
            end
            if (state == PEN) settle <= settle + 1'b1;
            // NOTE: non-blocking updates; when accept and period_start coincide, the
            // accumulator write below is the last one in the block and takes effect.
            if (period_start) begin
                acc_x        <= acc_x_next;
                acc_y        <= acc_y_next;
                x_step       <= hit_x;
                y_step       <= hit_y;
                phase        <= '0;
                periods_left <= (state == STEP) ? periods_left - 1'b1 : n_sel - 1'b1;
            end else if (state == STEP) begin
                phase <= phase + 1'b1;
                if (phase == PULSE_LAST || phase == PHASE_LAST) begin
                    x_step <= 1'b0;
                    y_step <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_xy_motion_sequencer.sv
// Self-checking bench for xy_motion_sequencer: directed scenarios plus random moves,
// compared cycle by cycle against a closed-form model of pen settle and DDA pulse timing.
module tb_xy_motion_sequencer;
    localparam int CW         = 16;
    localparam int STEP_DIV   = 10;
    localparam int PULSE_W    = 2;
    localparam int PEN_SETTLE = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [CW-1:0] cmd_dx = '0;
    logic [CW-1:0] cmd_dy = '0;
    logic          cmd_x_dir = 1'b0;
    logic          cmd_y_dir = 1'b0;
    logic          cmd_pen = 1'b0;
    logic          x_step, y_step, x_dir, y_dir, pen_down, busy, done;

    int errors = 0;
    int checks = 0;
    bit model_pen = 1'b0;
    int nx_dx, nx_dy;
    bit nx_xd, nx_yd, nx_pen;

    xy_motion_sequencer #(
        .CW(CW), .STEP_DIV(STEP_DIV), .PULSE_W(PULSE_W), .PEN_SETTLE(PEN_SETTLE)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dx(cmd_dx), .cmd_dy(cmd_dy), .cmd_x_dir(cmd_x_dir), .cmd_y_dir(cmd_y_dir),
        .cmd_pen(cmd_pen), .x_step(x_step), .y_step(y_step), .x_dir(x_dir), .y_dir(y_dir),
        .pen_down(pen_down), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Axis pulses in period k iff floor((k*d + n/2)/n) steps past floor(((k-1)*d + n/2)/n).
    function automatic bit pulse_in_period(int d, int n, int k);
        return ((k * d + n / 2) / n) != (((k - 1) * d + n / 2) / n);
    endfunction

    function automatic bit exp_step(int d, int n, int off, int c);
        int p;
        if (n == 0) return 1'b0;
        p = c - 1 - off;
        if (p < 0 || p >= n * STEP_DIV) return 1'b0;
        return ((p % STEP_DIV) < PULSE_W) && pulse_in_period(d, n, p / STEP_DIV + 1);
    endfunction

    task automatic issue(input int dx, input int dy, input bit xd, input bit yd, input bit pen);
        int waited = 0;
        while (!cmd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("ready_before_issue", cmd_ready, 1'b1);
        cmd_dx    = CW'(dx);
        cmd_dy    = CW'(dy);
        cmd_x_dir = xd;
        cmd_y_dir = yd;
        cmd_pen   = pen;
        cmd_valid = 1'b1;
    endtask

    // Follows one accepted move from the accept edge to the first IDLE cycle after done.
    task automatic trace(input int dx, input int dy, input bit xd, input bit yd, input bit pen,
                         input bit chain);
        int n, off, done_c;
        string t;
        n      = (dx > dy) ? dx : dy;
        off    = (pen != model_pen) ? PEN_SETTLE : 0;
        done_c = off + 1 + n * STEP_DIV;
        @(posedge clk);
        #1;
        if (chain) begin
            cmd_dx    = CW'(nx_dx);
            cmd_dy    = CW'(nx_dy);
            cmd_x_dir = nx_xd;
            cmd_y_dir = nx_yd;
            cmd_pen   = nx_pen;
        end else begin
            cmd_valid = 1'b0;
        end
        model_pen = pen;
        for (int c = 1; c <= done_c + 1; c++) begin
            @(negedge clk);
            t = $sformatf("move(%0d,%0d) T+%0d", dx, dy, c);
            check({t, " x_step"},    x_step,    exp_step(dx, n, off, c));
            check({t, " y_step"},    y_step,    exp_step(dy, n, off, c));
            check({t, " busy"},      busy,      c <= done_c);
            check({t, " done"},      done,      c == done_c);
            check({t, " cmd_ready"}, cmd_ready, c > done_c);
            check({t, " x_dir"},     x_dir,     xd);
            check({t, " y_dir"},     y_dir,     yd);
            check({t, " pen_down"},  pen_down,  pen);
        end
    endtask

    initial begin
        int rdx, rdy;
        bit rxd, ryd, rpen;

        // Reset state
        #12;
        check("rst cmd_ready", cmd_ready, 1'b0);
        check("rst x_step", x_step, 1'b0);
        check("rst y_step", y_step, 1'b0);
        check("rst pen_down", pen_down, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst dirs", {x_dir, y_dir}, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready after release", cmd_ready, 1'b1);
        @(negedge clk);

        // Straight X, diagonal ratio, zero move, pen change
        issue(4, 0, 1'b0, 1'b0, 1'b0); trace(4, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4, 2, 1'b1, 1'b1, 1'b0); trace(4, 2, 1'b1, 1'b1, 1'b0, 1'b0);
        issue(0, 0, 1'b0, 1'b0, 1'b0); trace(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(0, 3, 1'b0, 1'b1, 1'b1); trace(0, 3, 1'b0, 1'b1, 1'b1, 1'b0);

        // Busy: a command offered mid-move is ignored; then async reset in period 3
        issue(5, 0, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 5) begin
                cmd_valid = 1'b1; cmd_dx = 16'd1; cmd_x_dir = 1'b0; cmd_pen = 1'b0;
            end
            if (c == 8) cmd_valid = 1'b0;
            check($sformatf("busy_move T+%0d x_step", c), x_step, exp_step(5, 5, 0, c));
            check($sformatf("busy_move T+%0d x_dir", c), x_dir, 1'b1);
            check($sformatf("busy_move T+%0d pen_down", c), pen_down, 1'b1);
            check($sformatf("busy_move T+%0d busy", c), busy, 1'b1);
        end
        @(posedge clk);
        #1;
        check("period3 x_step before reset", x_step, 1'b1);
        reset = 1'b1;
        #1;
        check("async rst x_step", x_step, 1'b0);
        check("async rst pen_down", pen_down, 1'b0);
        check("async rst busy", busy, 1'b0);
        check("async rst cmd_ready", cmd_ready, 1'b0);
        check("async rst x_dir", x_dir, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        model_pen = 1'b0;
        @(posedge clk);
        #1;
        check("ready after mid-move reset", cmd_ready, 1'b1);
        @(negedge clk);
        issue(3, 1, 1'b1, 1'b0, 1'b0); trace(3, 1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Random moves
        for (int i = 0; i < 8; i++) begin
            rdx  = int'($urandom_range(0, 6));
            rdy  = int'($urandom_range(0, 6));
            rxd  = 1'($urandom_range(0, 1));
            ryd  = 1'($urandom_range(0, 1));
            rpen = 1'($urandom_range(0, 1));
            issue(rdx, rdy, rxd, ryd, rpen);
            trace(rdx, rdy, rxd, ryd, rpen, 1'b0);
        end

        // Back-to-back: cmd_valid held, second command waits for the IDLE cycle after done
        nx_dx = 3; nx_dy = 0; nx_xd = 1'b1; nx_yd = 1'b1; nx_pen = 1'b0;
        issue(2, 3, 1'b0, 1'b0, 1'b1);
        trace(2, 3, 1'b0, 1'b0, 1'b1, 1'b1);
        trace(3, 0, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
